// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: opcode constants, instruction field layout,
// fetch FSM states and the per-cycle action decoded by the interrupt sequencer.
package cpu_pkg;

   localparam int unsigned INST_W = 16;

   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_HLT = 5'b11111;

   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 11;
   localparam int unsigned RS_MSB     = 10;
   localparam int unsigned RS_LSB     = 8;
   localparam int unsigned RD_MSB     = 7;
   localparam int unsigned RD_LSB     = 5;
   localparam int unsigned SHMNT_MSB  = 4;
   localparam int unsigned SHMNT_LSB  = 0;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_INT_HANDLER  = 32'h0000_0010;

   typedef enum logic [1:0] {
      StRun,
      StInt1,
      StInt2,
      StHalt
   } fetch_state_t;

   // What the fetch stage does this cycle; resolved once so datapath and FSM agree.
   typedef enum logic [2:0] {
      ActFetch,
      ActBubble,
      ActRedirect,
      ActHold,
      ActInt1,
      ActInt2
   } fetch_act_t;

   typedef struct packed {
      logic [4:0] opcode;
      logic [2:0] rs;
      logic [2:0] rd;
      logic [4:0] shmnt;
   } inst_fields_t;

   function automatic inst_fields_t split_inst(input logic [INST_W-1:0] word);
      inst_fields_t f;
      f.opcode = word[OPCODE_MSB:OPCODE_LSB];
      f.rs     = word[RS_MSB:RS_LSB];
      f.rd     = word[RD_MSB:RD_LSB];
      f.shmnt  = word[SHMNT_MSB:SHMNT_LSB];
      return f;
   endfunction

   function automatic inst_fields_t bubble_fields(input logic [4:0] nop_opcode);
      inst_fields_t f;
      f.opcode = nop_opcode;
      f.rs     = '0;
      f.rd     = '0;
      f.shmnt  = '0;
      return f;
   endfunction

endpackage

// File: rtl/fetch_int_seq.sv
// Fetch control FSM: interrupt pending latch, RUN/HALT/INT1/INT2 state and the
// prioritised per-cycle action (redirect > stall > interrupt > normal).
module fetch_int_seq
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic         int_req,
   input  logic         hlt_fetched,
   output fetch_state_t state,
   output fetch_act_t   act
);

   fetch_state_t state_q, state_d;
   logic         pend_q, pend_d;

   always_comb begin
      act = ActHold;
      unique case (state_q)
         StRun, StHalt: begin
            if (redirect_valid) begin
               act = ActRedirect;
            end else if (stall) begin
               act = ActHold;
            end else if (pend_q) begin
               act = ActInt1;
            end else if (state_q == StRun) begin
               act = ActFetch;
            end else begin
               act = ActBubble;
            end
         end
         // Interrupt entry cannot be aborted by a redirect, only frozen by stall.
         StInt1: act = stall ? ActHold : ActInt2;
         StInt2: act = stall ? ActHold : ActFetch;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (act)
         ActFetch:    state_d = hlt_fetched ? StHalt : StRun;
         ActBubble:   state_d = StHalt;
         ActRedirect: state_d = StRun;
         ActInt1:     state_d = StInt1;
         ActInt2:     state_d = StInt2;
         default:     state_d = state_q;
      endcase
   end

   // Entering INT1 consumes the request; otherwise any int_req cycle latches it.
   always_comb begin
      pend_d = pend_q | int_req;
      if (act == ActInt1) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, field split of the fetched word and the
// F/D write-port drive, including redirect flush, halt parking and interrupt slots.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(cpu_pkg::DEF_RESET_VECTOR),
   parameter logic [ADDR_W-1:0] INT_HANDLER  = ADDR_W'(cpu_pkg::DEF_INT_HANDLER),
   parameter logic [4:0]        OP_NOP       = cpu_pkg::OP_NOP,
   parameter logic [4:0]        OP_HLT       = cpu_pkg::OP_HLT
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_data,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              int_req,
   output logic              fd_enable,
   output logic [ADDR_W-1:0] next_inst_addr,
   output logic [4:0]        opcode,
   output logic [2:0]        rs,
   output logic [2:0]        rd,
   output logic [4:0]        shmnt,
   output logic [ADDR_W-1:0] pc,
   output logic              int1,
   output logic              int2
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ret_q, ret_d;
   logic [ADDR_W-1:0] pc_inc;
   fetch_state_t      state;
   fetch_act_t        act;
   inst_fields_t      fetched;
   inst_fields_t      bubble;
   logic              hlt_fetched;

   inst_fields_t      slot;
   logic              slot_fd_en;
   logic [ADDR_W-1:0] slot_pc;
   logic [ADDR_W-1:0] slot_next;
   logic              slot_int1;
   logic              slot_int2;

   assign fetched     = split_inst(imem_data);
   assign bubble      = bubble_fields(OP_NOP);
   assign hlt_fetched = (fetched.opcode == OP_HLT);
   assign pc_inc      = pc_q + ADDR_W'(1);

   fetch_int_seq u_int_seq (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .int_req        (int_req),
      .hlt_fetched    (hlt_fetched),
      .state          (state),
      .act            (act)
   );

   always_comb begin
      pc_d  = pc_q;
      ret_d = ret_q;
      case (act)
         ActFetch:    pc_d = pc_inc;
         ActRedirect: pc_d = redirect_addr;
         ActInt1:     ret_d = pc_q;
         ActInt2:     pc_d = INT_HANDLER;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         ret_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ret_q <= ret_d;
      end
   end

   always_comb begin
      slot       = bubble;
      slot_fd_en = 1'b1;
      slot_pc    = pc_q;
      slot_next  = pc_inc;
      slot_int1  = 1'b0;
      slot_int2  = 1'b0;
      case (act)
         ActFetch: slot = fetched;
         ActInt1:  slot_int1 = 1'b1;
         ActInt2: begin
            slot_int2 = 1'b1;
            slot_pc   = ret_q;
            slot_next = INT_HANDLER;
         end
         // Held slot keeps showing what this state would emit, but is not written.
         ActHold: begin
            slot_fd_en = 1'b0;
            if (state == StRun || state == StInt2) begin
               slot = fetched;
            end else if (state == StInt1) begin
               slot_pc   = ret_q;
               slot_next = INT_HANDLER;
            end
         end
         default: ;
      endcase
   end

   // During reset every output is forced low so F/D sees no write.
   always_comb begin
      imem_addr      = '0;
      fd_enable      = 1'b0;
      next_inst_addr = '0;
      opcode         = '0;
      rs             = '0;
      rd             = '0;
      shmnt          = '0;
      pc             = '0;
      int1           = 1'b0;
      int2           = 1'b0;
      if (rst_n) begin
         imem_addr      = pc_q;
         fd_enable      = slot_fd_en;
         next_inst_addr = slot_next;
         opcode         = slot.opcode;
         rs             = slot.rs;
         rd             = slot.rd;
         shmnt          = slot.shmnt;
         pc             = slot_pc;
         int1           = slot_int1;
         int2           = slot_int2;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle stimulus/expectations plus
// hand sequences for halt parking and reset during interrupt entry.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        int_req;
   logic        fd_enable;
   logic [31:0] next_inst_addr;
   logic [4:0]  opcode;
   logic [2:0]  rs;
   logic [2:0]  rd;
   logic [4:0]  shmnt;
   logic [31:0] pc;
   logic        int1;
   logic        int2;

   logic [15:0] mem [256];

   int total;
   int bad;

   typedef struct {
      logic        st;
      logic        rv;
      logic [31:0] ra;
      logic        ir;
      logic        fd;
      logic [31:0] p;
      logic [31:0] nx;
      logic [4:0]  op;
      logic [2:0]  rs;
      logic [2:0]  rd;
      logic [4:0]  sh;
      logic        i1;
      logic        i2;
      logic        full;
   } vec_t;

   vec_t tbl [27];
   vec_t hs  [14];

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .int_req        (int_req),
      .fd_enable      (fd_enable),
      .next_inst_addr (next_inst_addr),
      .opcode         (opcode),
      .rs             (rs),
      .rd             (rd),
      .shmnt          (shmnt),
      .pc             (pc),
      .int1           (int1),
      .int2           (int2)
   );

   assign imem_data = mem[imem_addr[7:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] ra,
                               input logic ir, input logic fd, input logic [31:0] p,
                               input logic [31:0] nx, input logic [4:0] op,
                               input logic [2:0] rsv, input logic [2:0] rdv,
                               input logic [4:0] sh, input logic i1, input logic i2,
                               input logic full);
      vec_t v;
      v.st = st; v.rv = rv; v.ra = ra; v.ir = ir;
      v.fd = fd; v.p = p; v.nx = nx; v.op = op; v.rs = rsv; v.rd = rdv; v.sh = sh;
      v.i1 = i1; v.i2 = i2; v.full = full;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Entered at posedge+1; drives, checks at posedge+3, returns at next posedge+1.
   task automatic step(input vec_t v, input string tag);
      stall          = v.st;
      redirect_valid = v.rv;
      redirect_addr  = v.ra;
      int_req        = v.ir;
      #2;
      cmp({tag, ".fd_enable"}, 32'(fd_enable), 32'(v.fd));
      cmp({tag, ".pc"}, pc, v.p);
      if (v.full) begin
         cmp({tag, ".next"}, next_inst_addr, v.nx);
         cmp({tag, ".opcode"}, 32'(opcode), 32'(v.op));
         cmp({tag, ".rs"}, 32'(rs), 32'(v.rs));
         cmp({tag, ".rd"}, 32'(rd), 32'(v.rd));
         cmp({tag, ".shmnt"}, 32'(shmnt), 32'(v.sh));
         cmp({tag, ".int1"}, 32'(int1), 32'(v.i1));
         cmp({tag, ".int2"}, 32'(int2), 32'(v.i2));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      cmp({tag, ".fd_enable"}, 32'(fd_enable), 32'd0);
      cmp({tag, ".opcode"}, 32'(opcode), 32'd0);
      cmp({tag, ".pc"}, pc, 32'd0);
      cmp({tag, ".next"}, next_inst_addr, 32'd0);
      cmp({tag, ".imem_addr"}, imem_addr, 32'd0);
      cmp({tag, ".int1"}, 32'(int1), 32'd0);
      cmp({tag, ".int2"}, 32'(int2), 32'd0);
   endtask

   initial begin
      logic [7:0] idx;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      int_req        = 1'b0;

      // Filler word at address i: opcode 3, rs 5, rd 6, shmnt = i[4:0].
      for (int i = 0; i < 256; i++) begin
         idx = 8'(i);
         mem[i] = {5'd3, 3'd5, 3'd6, idx[4:0]};
      end
      mem[0] = 16'h0A25;
      mem[1] = 16'h1100;
      mem[2] = 16'h2345;

      //             st rv ra            ir fd pc            next          op     rs rd sh  i1 i2 full
      tbl[0]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        32'h1,        5'h01, 2, 1, 5,  0, 0, 1);
      tbl[1]  = mk(0, 0, 32'h0,        0, 1, 32'h1,        32'h2,        5'h02, 1, 0, 0,  0, 0, 1);
      tbl[2]  = mk(0, 0, 32'h0,        0, 1, 32'h2,        32'h3,        5'h04, 3, 2, 5,  0, 0, 1);
      tbl[3]  = mk(0, 0, 32'h0,        0, 1, 32'h3,        32'h4,        5'h03, 5, 6, 3,  0, 0, 1);
      tbl[4]  = mk(1, 0, 32'h0,        0, 0, 32'h4,        32'h5,        5'h03, 5, 6, 4,  0, 0, 1);
      tbl[5]  = mk(1, 0, 32'h0,        0, 0, 32'h4,        32'h5,        5'h03, 5, 6, 4,  0, 0, 1);
      tbl[6]  = mk(1, 0, 32'h0,        0, 0, 32'h4,        32'h5,        5'h03, 5, 6, 4,  0, 0, 1);
      tbl[7]  = mk(0, 0, 32'h0,        0, 1, 32'h4,        32'h5,        5'h03, 5, 6, 4,  0, 0, 1);
      tbl[8]  = mk(0, 0, 32'h0,        0, 1, 32'h5,        32'h6,        5'h03, 5, 6, 5,  0, 0, 1);
      tbl[9]  = mk(0, 0, 32'h0,        0, 1, 32'h6,        32'h7,        5'h03, 5, 6, 6,  0, 0, 1);
      tbl[10] = mk(0, 1, 32'h40,       0, 1, 32'h7,        32'h8,        5'h00, 0, 0, 0,  0, 0, 1);
      tbl[11] = mk(0, 0, 32'h0,        1, 1, 32'h40,       32'h41,       5'h03, 5, 6, 0,  0, 0, 1);
      tbl[12] = mk(0, 0, 32'h0,        0, 1, 32'h41,       32'h42,       5'h00, 0, 0, 0,  1, 0, 1);
      tbl[13] = mk(0, 0, 32'h0,        0, 1, 32'h41,       32'h10,       5'h00, 0, 0, 0,  0, 1, 1);
      tbl[14] = mk(0, 0, 32'h0,        0, 1, 32'h10,       32'h11,       5'h03, 5, 6, 16, 0, 0, 1);
      tbl[15] = mk(1, 0, 32'h0,        1, 0, 32'h11,       32'h12,       5'h03, 5, 6, 17, 0, 0, 1);
      tbl[16] = mk(1, 0, 32'h0,        0, 0, 32'h11,       32'h12,       5'h03, 5, 6, 17, 0, 0, 1);
      tbl[17] = mk(0, 0, 32'h0,        0, 1, 32'h11,       32'h12,       5'h00, 0, 0, 0,  1, 0, 1);
      tbl[18] = mk(0, 0, 32'h0,        0, 1, 32'h11,       32'h10,       5'h00, 0, 0, 0,  0, 1, 1);
      tbl[19] = mk(0, 0, 32'h0,        1, 1, 32'h10,       32'h11,       5'h03, 5, 6, 16, 0, 0, 1);
      tbl[20] = mk(0, 0, 32'h0,        0, 1, 32'h11,       32'h12,       5'h00, 0, 0, 0,  1, 0, 1);
      tbl[21] = mk(1, 1, 32'h80,       0, 0, 32'h11,       32'h0,        5'h00, 0, 0, 0,  0, 0, 0);
      tbl[22] = mk(0, 1, 32'h80,       0, 1, 32'h11,       32'h10,       5'h00, 0, 0, 0,  0, 1, 1);
      tbl[23] = mk(0, 1, 32'h80,       0, 1, 32'h10,       32'h11,       5'h03, 5, 6, 16, 0, 0, 1);
      tbl[24] = mk(0, 1, 32'hFFFF_FFFF, 0, 1, 32'h11,       32'h12,       5'h00, 0, 0, 0,  0, 0, 1);
      tbl[25] = mk(0, 0, 32'h0,        0, 1, 32'hFFFF_FFFF, 32'h0,        5'h03, 5, 6, 31, 0, 0, 1);
      tbl[26] = mk(0, 0, 32'h0,        0, 1, 32'h0,        32'h1,        5'h01, 2, 1, 5,  0, 0, 1);

      // Halt parking at pc 5, then interrupt out of HALT and into a second entry.
      for (int k = 0; k < 5; k++) begin
         hs[k] = mk(0, 0, 32'h0, 0, 1, 32'(k), 32'(k + 1), 5'h00, 0, 0, 0, 0, 0, 0);
      end
      hs[5]  = mk(0, 0, 32'h0, 0, 1, 32'h5,  32'h6,  5'h1F, 0, 0, 0,  0, 0, 1);
      hs[6]  = mk(0, 0, 32'h0, 0, 1, 32'h6,  32'h7,  5'h00, 0, 0, 0,  0, 0, 1);
      hs[7]  = mk(1, 0, 32'h0, 0, 0, 32'h6,  32'h7,  5'h00, 0, 0, 0,  0, 0, 1);
      hs[8]  = mk(0, 0, 32'h0, 1, 1, 32'h6,  32'h7,  5'h00, 0, 0, 0,  0, 0, 1);
      hs[9]  = mk(0, 0, 32'h0, 0, 1, 32'h6,  32'h7,  5'h00, 0, 0, 0,  1, 0, 1);
      hs[10] = mk(0, 0, 32'h0, 0, 1, 32'h6,  32'h10, 5'h00, 0, 0, 0,  0, 1, 1);
      hs[11] = mk(0, 0, 32'h0, 0, 1, 32'h10, 32'h11, 5'h03, 5, 6, 16, 0, 0, 1);
      hs[12] = mk(0, 0, 32'h0, 1, 1, 32'h11, 32'h12, 5'h03, 5, 6, 17, 0, 0, 1);
      hs[13] = mk(0, 0, 32'h0, 0, 1, 32'h12, 32'h13, 5'h00, 0, 0, 0,  1, 0, 1);

      // Outputs gated while in reset even though mem[0] has a non-zero opcode.
      #3;
      check_reset_outputs("rst0");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         step(tbl[i], $sformatf("A%0d", i));
      end

      rst_n = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      int_req = 1'b0;
      mem[5] = 16'hF800;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step(hs[i], $sformatf("H%0d", i));
      end

      // Now in INT1 with pc_q=0x12; reset here must drop the pending int2 slot.
      rst_n = 1'b0;
      #2;
      check_reset_outputs("rst_int1");
      @(posedge clk);
      #1;
      check_reset_outputs("rst_int1_edge");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(0, 0, 32'h0, 0, 1, 32'h0, 32'h1, 5'h01, 2, 1, 5, 0, 0, 1), "R0");
      step(mk(0, 0, 32'h0, 0, 1, 32'h1, 32'h2, 5'h02, 1, 0, 0, 0, 0, 1), "R1");
      step(mk(0, 0, 32'h0, 0, 1, 32'h2, 32'h3, 5'h04, 3, 2, 5, 0, 0, 1), "R2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
